// File: rtl/rom_access_ctrl.sv
// rtl/rom_access_ctrl.sv - two-requester (IF/DR) arbiter for the program ROM read port
// Grants are combinational; responses come back one cycle later with a single-cycle valid.
module rom_access_ctrl #(
  parameter logic [15:0] BOUND_U       = 16'hffff,
  parameter logic [15:0] BOUND_L       = 16'hc000,
  parameter int          MAX_DR_STREAK = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        if_flush,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [15:0] if_rdata,
  output logic        if_err,
  input  logic        dr_req,
  input  logic [15:0] dr_addr,
  output logic        dr_gnt,
  output logic        dr_rvalid,
  output logic [15:0] dr_rdata,
  output logic        dr_err,
  output logic [15:0] rom_addr,
  input  logic [15:0] rom_out
);

  localparam int SW = (MAX_DR_STREAK < 2) ? 1 : $clog2(MAX_DR_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DR_STREAK);

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DR} owner_t;

  owner_t        owner;
  logic [SW-1:0] streak;
  logic [15:0]   if_cap;
  logic [15:0]   if_rdata_q;
  logic          if_err_q;
  logic [15:0]   dr_rdata_q;
  logic          dr_err_q;

  logic          if_starved;
  logic          any_gnt;
  logic [15:0]   gnt_addr;
  logic          addr_ok;
  logic [15:0]   gnt_data;

  // IF only beats DR once DR has won MAX_DR_STREAK times in a row against it
  assign if_starved = if_req && (streak == STREAK_MAX);
  assign dr_gnt     = dr_req && !if_starved;
  assign if_gnt     = if_req && !if_flush && !dr_gnt;
  assign any_gnt    = dr_gnt || if_gnt;

  assign gnt_addr = dr_gnt ? dr_addr : if_addr;
  assign addr_ok  = (gnt_addr >= BOUND_L) && (gnt_addr < BOUND_U) && !gnt_addr[0];
  assign rom_addr = (any_gnt && addr_ok) ? (gnt_addr - BOUND_L) : 16'h0000;
  assign gnt_data = addr_ok ? rom_out : 16'h0000;

  // A flush arriving in the response cycle hides the IF response and keeps old if_rdata
  assign if_rvalid = (owner == OWN_IF) && !if_flush;
  assign if_err    = if_rvalid && if_err_q;
  assign if_rdata  = if_rvalid ? if_cap : if_rdata_q;
  assign dr_rvalid = (owner == OWN_DR);
  assign dr_err    = dr_err_q;
  assign dr_rdata  = dr_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= OWN_NONE;
      streak     <= '0;
      if_cap     <= 16'h0000;
      if_rdata_q <= 16'h0000;
      if_err_q   <= 1'b0;
      dr_rdata_q <= 16'h0000;
      dr_err_q   <= 1'b0;
    end else begin
      if (dr_gnt)
        owner <= OWN_DR;
      else if (if_gnt)
        owner <= OWN_IF;
      else
        owner <= OWN_NONE;

      if (dr_gnt)
        dr_rdata_q <= gnt_data;
      dr_err_q <= dr_gnt && !addr_ok;

      if (if_gnt) begin
        if_cap   <= gnt_data;
        if_err_q <= !addr_ok;
      end
      if (if_rvalid)
        if_rdata_q <= if_cap;

      if (!if_req || if_gnt)
        streak <= '0;
      else if (dr_gnt && (streak != STREAK_MAX))
        streak <= streak + 1'b1;
    end
  end

endmodule
